fadd_issue_ctrl: RTL and testbench

Issue controller that shares one fixed-latency pipelined FP32 adder (far/near-path FADD) between two requesters, e.g. the FMA add stage (port 0) and the standalone FADD issue port (port 1). It arbitrates round-robin, registers the operands into the adder, and tracks each in-flight operation's source, tag and kill status. Results are returned through per-requester response FIFOs, and a credit scheme means the adder is never stalled. It sits between the FP issue logic and the FADD datapath.

---
 rtl/fadd_ctrl_pkg.sv | 26 ++
 rtl/fadd_rsp_fifo.sv | 65 ++++++
 rtl/fadd_issue_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_fadd_issue_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fadd_ctrl_pkg.sv
// rtl/fadd_ctrl_pkg.sv - shared widths and types for the FADD issue controller
package fadd_ctrl_pkg;

    localparam int FP_W      = 32;
    localparam int FFLAGS_W  = 5;
    localparam int RM_W      = 3;
    // Tag field width held in the tracker; the top-level TAG_W must not exceed it.
    localparam int TRK_TAG_W = 8;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_e;

    typedef struct packed {
        logic                 valid;
        src_e                 src;
        logic [TRK_TAG_W-1:0] tag;
        logic                 killed;
    } trk_entry_t;

    function automatic src_e other_src(input src_e s);
        return (s == SRC0) ? SRC1 : SRC0;
    endfunction

endpackage

// File: rtl/fadd_rsp_fifo.sv
// rtl/fadd_rsp_fifo.sv - synchronous response FIFO with flush and occupancy count
module fadd_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push_tvalid,
    input  logic [WIDTH-1:0] push_tdata,
    output logic             pop_tvalid,
    input  logic             pop_tready,
    output logic [WIDTH-1:0] pop_tdata,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_tvalid = (count != '0);
    assign pop_tdata  = mem[rd_ptr];
    assign push       = push_tvalid && !flush;
    assign pop        = pop_tvalid && pop_tready && !flush;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_tdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fadd_issue_ctrl.sv
// rtl/fadd_issue_ctrl.sv - two-port round-robin issue controller for a shared pipelined FP32 adder
module fadd_issue_ctrl
    import fadd_ctrl_pkg::*;
#(
    parameter int LATENCY   = 3,
    parameter int TAG_W     = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [FP_W-1:0]     req0_a,
    input  logic [FP_W-1:0]     req0_b,
    input  logic [RM_W-1:0]     req0_rm,
    input  logic [TAG_W-1:0]    req0_tag,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [FP_W-1:0]     req1_a,
    input  logic [FP_W-1:0]     req1_b,
    input  logic [RM_W-1:0]     req1_rm,
    input  logic [TAG_W-1:0]    req1_tag,

    output logic                fadd_in_valid,
    output logic [FP_W-1:0]     fadd_in_a,
    output logic [FP_W-1:0]     fadd_in_b,
    output logic [RM_W-1:0]     fadd_in_rm,
    input  logic                fadd_out_valid,
    input  logic [FP_W-1:0]     fadd_out_result,
    input  logic [FFLAGS_W-1:0] fadd_out_fflags,

    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [FP_W-1:0]     rsp0_result,
    output logic [FFLAGS_W-1:0] rsp0_fflags,
    output logic [TAG_W-1:0]    rsp0_tag,

    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [FP_W-1:0]     rsp1_result,
    output logic [FFLAGS_W-1:0] rsp1_fflags,
    output logic [TAG_W-1:0]    rsp1_tag,

    output logic                err_latency
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int RSP_W = FFLAGS_W + TAG_W + FP_W;

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       rsp_valid;
    logic [1:0]       pop;
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       push;
    logic [1:0]       dec;
    logic [CNT_W-1:0] fifo_cnt [2];
    logic [CNT_W-1:0] inflight [2];
    logic [CNT_W-1:0] cnt_eff  [2];
    logic [RSP_W-1:0] push_data;
    logic [RSP_W-1:0] rsp_data0;
    logic [RSP_W-1:0] rsp_data1;

    src_e             rr;
    src_e             gsrc;
    trk_entry_t       trk [LATENCY+1];
    trk_entry_t       new_entry;
    trk_entry_t       head;
    logic             head_live;

    assign req_valid  = {req1_valid, req0_valid};
    assign rsp_ready  = {rsp1_ready, rsp0_ready};
    assign rsp_valid  = {rsp1_valid, rsp0_valid};
    assign pop        = rsp_valid & rsp_ready;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // A pop this cycle returns its credit immediately, so it is subtracted before the compare.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_eff[i] = fifo_cnt[i] + inflight[i] - CNT_W'(pop[i]);
            elig[i]    = req_valid[i] && (cnt_eff[i] < CNT_W'(RSP_DEPTH)) && !flush && reset_n;
        end
    end

    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = (rr == SRC0) ? 2'b01 : 2'b10;
        end
        gsrc = grant[1] ? SRC1 : SRC0;
    end

    always_comb begin
        new_entry        = '0;
        new_entry.valid  = |grant;
        new_entry.src    = gsrc;
        new_entry.tag    = grant[1] ? TRK_TAG_W'(req1_tag) : TRK_TAG_W'(req0_tag);
        new_entry.killed = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fadd_in_valid <= 1'b0;
            fadd_in_a     <= '0;
            fadd_in_b     <= '0;
            fadd_in_rm    <= '0;
            rr            <= SRC0;
        end else begin
            fadd_in_valid <= |grant;
            if (|grant) begin
                fadd_in_a  <= grant[1] ? req1_a  : req0_a;
                fadd_in_b  <= grant[1] ? req1_b  : req0_b;
                fadd_in_rm <= grant[1] ? req1_rm : req0_rm;
                rr         <= other_src(gsrc);
            end
        end
    end

    // Stage 0 is loaded with the issue, so stage LATENCY lines up with the adder output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= LATENCY; i++) begin
                trk[i] <= '0;
            end
        end else begin
            trk[0] <= new_entry;
            for (int i = 1; i <= LATENCY; i++) begin
                trk[i] <= trk[i-1];
                if (flush) begin
                    trk[i].killed <= 1'b1;
                end
            end
        end
    end

    assign head      = trk[LATENCY];
    assign head_live = head.valid && !head.killed;

    always_comb begin
        push = '0;
        dec  = '0;
        for (int i = 0; i < 2; i++) begin
            dec[i]  = head_live && (head.src == src_e'(i));
            push[i] = dec[i] && fadd_out_valid && !flush;
        end
    end

    // Killed entries leave without touching inflight, which the flush already zeroed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight[0] <= '0;
            inflight[1] <= '0;
            err_latency <= 1'b0;
        end else begin
            if (fadd_out_valid != head.valid) begin
                err_latency <= 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (flush) begin
                    inflight[i] <= '0;
                end else begin
                    case ({grant[i], dec[i]})
                        2'b10:   inflight[i] <= inflight[i] + CNT_W'(1);
                        2'b01:   inflight[i] <= inflight[i] - CNT_W'(1);
                        default: inflight[i] <= inflight[i];
                    endcase
                end
            end
        end
    end

    assign push_data = {fadd_out_fflags, TAG_W'(head.tag), fadd_out_result};

    fadd_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .push_tvalid (push[0]),
        .push_tdata  (push_data),
        .pop_tvalid  (rsp0_valid),
        .pop_tready  (rsp0_ready),
        .pop_tdata   (rsp_data0),
        .count       (fifo_cnt[0])
    );

    fadd_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .push_tvalid (push[1]),
        .push_tdata  (push_data),
        .pop_tvalid  (rsp1_valid),
        .pop_tready  (rsp1_ready),
        .pop_tdata   (rsp_data1),
        .count       (fifo_cnt[1])
    );

    assign {rsp0_fflags, rsp0_tag, rsp0_result} = rsp_data0;
    assign {rsp1_fflags, rsp1_tag, rsp1_result} = rsp_data1;

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// tb/tb_fadd_issue_ctrl.sv - directed self-checking bench for fadd_issue_ctrl
module tb_fadd_issue_ctrl;

    localparam int LAT = 3;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_rm, req1_rm;
    logic [7:0]  req0_tag, req1_tag;
    logic        fadd_in_valid;
    logic [31:0] fadd_in_a, fadd_in_b;
    logic [2:0]  fadd_in_rm;
    logic        fadd_out_valid;
    logic [31:0] fadd_out_result;
    logic [4:0]  fadd_out_fflags;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [4:0]  rsp0_fflags, rsp1_fflags;
    logic [7:0]  rsp0_tag, rsp1_tag;
    logic        err_latency;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop0  = 0;
    int n_pop1  = 0;
    logic extra_dly = 1'b0;

    fadd_issue_ctrl #(.LATENCY(LAT), .TAG_W(8), .RSP_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_rm(req0_rm), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_rm(req1_rm), .req1_tag(req1_tag),
        .fadd_in_valid(fadd_in_valid), .fadd_in_a(fadd_in_a), .fadd_in_b(fadd_in_b),
        .fadd_in_rm(fadd_in_rm), .fadd_out_valid(fadd_out_valid),
        .fadd_out_result(fadd_out_result), .fadd_out_fflags(fadd_out_fflags),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_fflags(rsp0_fflags), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_fflags(rsp1_fflags), .rsp1_tag(rsp1_tag),
        .err_latency(err_latency)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    function automatic logic [4:0] model_flags(input logic [2:0] rm);
        return {2'b00, rm};
    endfunction

    // Model adder: LAT-stage pipeline, optionally one stage too slow.
    logic        mv [LAT+1];
    logic [31:0] mr [LAT+1];
    logic [4:0]  mf [LAT+1];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= LAT; i++) begin
                mv[i] <= 1'b0; mr[i] <= '0; mf[i] <= '0;
            end
        end else begin
            mv[0] <= fadd_in_valid;
            mr[0] <= model_add(fadd_in_a, fadd_in_b);
            mf[0] <= model_flags(fadd_in_rm);
            for (int i = 1; i <= LAT; i++) begin
                mv[i] <= mv[i-1]; mr[i] <= mr[i-1]; mf[i] <= mf[i-1];
            end
        end
    end

    assign fadd_out_valid  = extra_dly ? mv[LAT]   : mv[LAT-1];
    assign fadd_out_result = extra_dly ? mr[LAT]   : mr[LAT-1];
    assign fadd_out_fflags = extra_dly ? mf[LAT]   : mf[LAT-1];

    typedef struct {
        logic [7:0]  tag;
        logic [31:0] res;
        logic [4:0]  ff;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];

    always @(negedge clock) begin
        exp_t e;
        if (!reset_n || flush) begin
            exp0.delete();
            exp1.delete();
        end else begin
            if (rsp0_valid && rsp0_ready) begin
                n_pop0++;
                chk("rsp0_expected", 64'(exp0.size() != 0), 1);
                if (exp0.size() != 0) begin
                    e = exp0.pop_front();
                    chk("rsp0_tag", rsp0_tag, e.tag);
                    chk("rsp0_result", rsp0_result, e.res);
                    chk("rsp0_fflags", rsp0_fflags, e.ff);
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                n_pop1++;
                chk("rsp1_expected", 64'(exp1.size() != 0), 1);
                if (exp1.size() != 0) begin
                    e = exp1.pop_front();
                    chk("rsp1_tag", rsp1_tag, e.tag);
                    chk("rsp1_result", rsp1_result, e.res);
                    chk("rsp1_fflags", rsp1_fflags, e.ff);
                end
            end
            if (req0_valid && req0_ready)
                exp0.push_back('{tag: req0_tag, res: model_add(req0_a, req0_b), ff: model_flags(req0_rm)});
            if (req1_valid && req1_ready)
                exp1.push_back('{tag: req1_tag, res: model_add(req1_a, req1_b), ff: model_flags(req1_rm)});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; flush = 0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
    endtask

    initial begin
        int   g;
        int   p0;
        logic seen;
        logic [7:0] t0, t1;

        reset_n = 0; flush = 0;
        req0_valid = 1; req0_a = 32'h1; req0_b = 32'h2; req0_rm = 0; req0_tag = 8'h01;
        req1_valid = 0; req1_a = 32'h10; req1_b = 32'h20; req1_rm = 3'd1; req1_tag = 8'h81;
        rsp0_ready = 1; rsp1_ready = 1;
        #2;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_fadd_in_valid", fadd_in_valid, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_err", err_latency, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1; req0_valid = 0;

        // Single request, fixed latency check
        step();
        req0_valid = 1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_rm = 0; req0_tag = 8'h5A;
        #1 chk("single_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        #1;
        chk("single_in_valid", fadd_in_valid, 1);
        chk("single_in_a", fadd_in_a, 32'h3F80_0000);
        chk("single_in_b", fadd_in_b, 32'h4000_0000);
        chk("single_in_rm", fadd_in_rm, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            #1 chk($sformatf("single_rsp_valid_k%0d", k), rsp0_valid, (k == 4));
            if (k == 4) begin
                chk("single_result", rsp0_result, 32'h4040_0000);
                chk("single_fflags", rsp0_fflags, 0);
                chk("single_tag", rsp0_tag, 8'h5A);
            end
        end
        repeat (3) step();

        // Both requesters continuously valid: strict alternation
        do_reset();
        t0 = 8'h00; t1 = 8'h40;
        req0_valid = 1; req1_valid = 1;
        for (int k = 0; k < 8; k++) begin
            req0_tag = t0; req1_tag = t1;
            req0_a = 32'(k); req1_a = 32'(k * 3);
            #1;
            chk($sformatf("rr_ready0_c%0d", k), req0_ready, (k % 2 == 0));
            chk($sformatf("rr_ready1_c%0d", k), req1_ready, (k % 2 == 1));
            if (req0_ready) t0++;
            if (req1_ready) t1++;
            step();
        end
        idle_inputs();
        repeat (10) step();
        chk("rr_sb0_empty", exp0.size(), 0);
        chk("rr_sb1_empty", exp1.size(), 0);
        chk("rr_pops0", n_pop0, 5);
        chk("rr_pops1", n_pop1, 4);

        // Backpressure on rsp0: credits cap grants at 4, a pop returns one credit same cycle
        do_reset();
        rsp0_ready = 0; t0 = 8'h20; g = 0;
        req0_valid = 1;
        for (int k = 0; k < 10; k++) begin
            req0_tag = t0;
            #1;
            if (req0_ready) begin g++; t0++; end
            step();
        end
        req0_tag = t0;
        #1;
        chk("bp_grants", g, 4);
        chk("bp_ready_stalled", req0_ready, 0);
        step();
        rsp0_ready = 1;
        #1 chk("bp_credit_return", req0_ready, 1);
        if (req0_ready) t0++;
        step();
        rsp0_ready = 0; req0_tag = t0;
        #1 chk("bp_single_credit", req0_ready, 0);
        step();
        req1_valid = 1; t1 = 8'h90;
        for (int k = 0; k < 4; k++) begin
            req1_tag = t1;
            #1;
            chk($sformatf("bp_req1_ready_c%0d", k), req1_ready, 1);
            chk($sformatf("bp_req0_blocked_c%0d", k), req0_ready, 0);
            t1++;
            step();
        end
        idle_inputs();
        rsp0_ready = 1;
        repeat (14) step();
        chk("bp_sb0_empty", exp0.size(), 0);
        chk("bp_sb1_empty", exp1.size(), 0);

        // Flush with one queued and two in flight for req0
        do_reset();
        rsp0_ready = 0;
        req0_valid = 1; req0_tag = 8'h10; step();
        req0_valid = 0; step(); step();
        req0_valid = 1; req0_tag = 8'h11; step();
        req0_tag = 8'h12; step();
        flush = 1; req0_tag = 8'h13;
        #1 chk("flush_ready_low", req0_ready, 0);
        step();
        flush = 0;
        #1 chk("flush_ready_next", req0_ready, 1);
        g = 0; t0 = 8'h13;
        for (int k = 0; k < 10; k++) begin
            req0_tag = t0;
            #1;
            if (req0_ready) begin g++; t0++; end
            step();
        end
        chk("flush_full_credits", g, 4);
        idle_inputs();
        p0 = n_pop0;
        rsp0_ready = 1;
        repeat (12) step();
        chk("flush_post_pops", n_pop0 - p0, 4);
        chk("flush_sb0_empty", exp0.size(), 0);

        // Adder one cycle late: sticky latency error
        do_reset();
        extra_dly = 1;
        req1_valid = 1; req1_tag = 8'h21; step();
        req1_valid = 0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            #1 if (rsp1_valid) seen = 1;
            step();
        end
        chk("lat_err_set", err_latency, 1);
        chk("lat_dropped", seen, 0);
        extra_dly = 0;
        p0 = n_pop0;
        req0_valid = 1; req0_tag = 8'h22; step();
        req0_valid = 0;
        repeat (8) step();
        chk("lat_err_sticky", err_latency, 1);
        chk("lat_later_rsp", n_pop0 - p0, 1);
        reset_n = 0;
        #1 chk("lat_err_cleared", err_latency, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1;

        // Reset with three operations in flight
        step();
        rsp0_ready = 1;
        req0_valid = 1;
        for (int k = 0; k < 3; k++) begin
            req0_tag = 8'h60 + 8'(k);
            step();
        end
        reset_n = 0;
        #1;
        chk("mrst_in_valid", fadd_in_valid, 0);
        chk("mrst_rsp0_valid", rsp0_valid, 0);
        chk("mrst_rsp1_valid", rsp1_valid, 0);
        chk("mrst_req0_ready", req0_ready, 0);
        chk("mrst_err", err_latency, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1; req0_valid = 0;
        step();
        req0_valid = 1; req0_tag = 8'h77; req0_a = 32'h5; req0_b = 32'h6;
        step();
        req0_valid = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            #1;
            if (rsp0_valid) begin
                seen = 1;
                chk("mrst_first_tag", rsp0_tag, 8'h77);
            end
            step();
        end
        chk("mrst_rsp_seen", seen, 1);
        chk("mrst_err_after", err_latency, 0);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
